// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffers: stage payload structs,
// buffer state encoding and default widths.
package pipe_pkg;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_buf_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    // Number of entries held in a given buffer state.
    function automatic logic [1:0] state_occupancy(input pipe_buf_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the stage stall statistics; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with flush, optional 2-entry
// skid buffer and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH       = PIPE_WIDTH_DEF,
    parameter bit SKID        = 1'b1,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_buf_state_e  state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg;
    logic             in_fire;
    logic             out_fire;
    logic             bubble_clr;

    assign out_valid = (state_reg != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_occupancy(state_reg);

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clr;

            // Registered ready: depends only on state, breaking the out_ready path.
            assign in_ready  = (state_reg != FULL);
            assign skid_load = ~flush & (state_reg == ONE) & in_fire & ~out_fire;
            assign skid_clr  = bubble_clr & (flush | ((state_reg == FULL) & out_fire));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    skid_reg <= '0;
                end else if (skid_load) begin
                    skid_reg <= in_data;
                end else if (skid_clr) begin
                    skid_reg <= '0;
                end
            end
        end else begin : g_no_skid
            assign in_ready = ~out_valid | out_ready;
            assign skid_reg = '0;
        end
    endgenerate

    generate
        if (ZERO_BUBBLE) begin : g_zero_bubble
            assign bubble_clr = 1'b1;
            assign out_data   = out_valid ? main_reg : '0;
        end else begin : g_keep_bubble
            assign bubble_clr = 1'b0;
            assign out_data   = main_reg;
        end
    endgenerate

    // Flush wins over any handshake; an out_fire in that cycle is still consumed.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        if (flush) begin
            state_next = EMPTY;
            if (bubble_clr) begin
                main_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire && SKID) begin
                        state_next = FULL;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                        if (bubble_clr) begin
                            main_next = '0;
                        end
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid & ~out_ready),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance and a single-register instance run
// side by side against a FIFO-level reference model.
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        out_ready;
    logic        in_valid_w [2];
    logic [31:0] in_data_w  [2];
    logic        in_ready_w [2];
    logic        out_valid_w[2];
    logic [31:0] out_data_w [2];
    logic [1:0]  occ_w      [2];
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    bit          vgate[2];
    logic [31:0] src_buf[2][64];
    int          src_rd[2];
    int          src_wr[2];

    int          m_cnt[2];
    logic [31:0] m_ent[2][2];
    int          m_stall[2];
    int          m_max[2];
    bit          m_skid[2];

    int n_tests;
    int n_fail;
    int seen55;
    int max_occ_b;

    pipe_stage_buf #(
        .WIDTH(32), .SKID(1'b1), .ZERO_BUBBLE(1'b1), .CNT_W(16)
    ) u_dut_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]), .in_data(in_data_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .occupancy(occ_w[0]), .stall_cnt(stall_a)
    );

    pipe_stage_buf #(
        .WIDTH(32), .SKID(1'b0), .ZERO_BUBBLE(1'b1), .CNT_W(4)
    ) u_dut_flop (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]), .in_data(in_data_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .occupancy(occ_w[1]), .stall_cnt(stall_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int i, input logic [31:0] d);
        src_buf[i][src_wr[i] & 63] = d;
        src_wr[i]++;
    endtask

    task automatic push_both(input logic [31:0] d);
        push_src(0, d);
        push_src(1, d);
    endtask

    task automatic clear_src();
        for (int i = 0; i < 2; i++) begin
            src_rd[i] = src_wr[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
        end
        clear_src();
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_valid[%0d]", tag, i), 32'(out_valid_w[i]), 32'd0);
            check_eq($sformatf("%s_data[%0d]", tag, i), out_data_w[i], 32'd0);
            check_eq($sformatf("%s_occ[%0d]", tag, i), 32'(occ_w[i]), 32'd0);
            check_eq($sformatf("%s_rdy[%0d]", tag, i), 32'(in_ready_w[i]), 32'd1);
        end
        check_eq($sformatf("%s_stall[0]", tag), 32'(stall_a), 32'd0);
        check_eq($sformatf("%s_stall[1]", tag), 32'(stall_b), 32'd0);
    endtask

    // Asynchronous reset pulse between edges; returns at posedge+1 after release.
    task automatic pulse_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, check and model at negedge.
    task automatic tick();
        bit          exp_rdy;
        bit          exp_ov;
        logic [31:0] exp_od;
        bit          fire_in;
        bit          fire_out;
        for (int i = 0; i < 2; i++) begin
            in_valid_w[i] = (src_wr[i] != src_rd[i]) && vgate[i];
            in_data_w[i]  = src_buf[i][src_rd[i] & 63];
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_rdy = m_skid[i] ? (m_cnt[i] < 2) : ((m_cnt[i] == 0) || out_ready);
            exp_ov  = (m_cnt[i] > 0);
            exp_od  = exp_ov ? m_ent[i][0] : 32'd0;
            check_eq($sformatf("in_ready[%0d]", i), 32'(in_ready_w[i]), 32'(exp_rdy));
            check_eq($sformatf("out_valid[%0d]", i), 32'(out_valid_w[i]), 32'(exp_ov));
            check_eq($sformatf("out_data[%0d]", i), out_data_w[i], exp_od);
            check_eq($sformatf("occupancy[%0d]", i), 32'(occ_w[i]), 32'(m_cnt[i]));
            check_eq($sformatf("stall_cnt[%0d]", i),
                     (i == 0) ? 32'(stall_a) : 32'(stall_b), 32'(m_stall[i]));
            if (i == 1 && int'(occ_w[1]) > max_occ_b) max_occ_b = int'(occ_w[1]);
            if (out_valid_w[i] && out_ready && out_data_w[i] == 32'h55) seen55 = 1;

            fire_in  = in_valid_w[i] && exp_rdy;
            fire_out = exp_ov && out_ready;
            if (fire_out) $display("[TB] u%0d t=%0t out 0x%08h%s", i, $time, exp_od,
                                   flush ? " (flush cycle)" : "");
            if (exp_ov && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                if (fire_out) begin
                    m_ent[i][0] = m_ent[i][1];
                    m_cnt[i]--;
                end
                if (fire_in) begin
                    m_ent[i][m_cnt[i]] = in_data_w[i];
                    m_cnt[i]++;
                end
            end
            if (fire_in) src_rd[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; seen55 = 0; max_occ_b = 0;
        m_max[0] = 65535; m_max[1] = 15;
        m_skid[0] = 1'b1; m_skid[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vgate[i] = 1'b1; src_rd[i] = 0; src_wr[i] = 0;
            in_valid_w[i] = 1'b0; in_data_w[i] = 32'd0;
            m_ent[i][0] = 32'd0; m_ent[i][1] = 32'd0;
        end
        model_reset();
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        check_reset("rst0");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Back-to-back streaming.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push_both(32'(k));
        repeat (10) tick();

        // Backpressure fills the skid instance.
        push_both(32'h10); push_both(32'h11); push_both(32'h12);
        out_ready = 1'b0;
        repeat (4) tick();
        check_eq("bp_occ", 32'(occ_w[0]), 32'd2);
        check_eq("bp_rdy", 32'(in_ready_w[0]), 32'd0);
        check_eq("bp_head", out_data_w[0], 32'h10);
        check_eq("bp_stall", 32'(stall_a), 32'd3);
        out_ready = 1'b1;
        repeat (6) tick();

        // Reset while FULL.
        push_both(32'hA1); push_both(32'hA2);
        out_ready = 1'b0;
        repeat (3) tick();
        check_eq("pre_rst_occ", 32'(occ_w[0]), 32'd2);
        pulse_reset("rst_mid");

        // Flush of a FULL buffer with a pending input, then flush of an accepted input.
        push_both(32'h31); push_both(32'h32);
        repeat (3) tick();
        push_both(32'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_src();
        check_eq("flush_valid", 32'(out_valid_w[0]), 32'd0);
        check_eq("flush_data", out_data_w[0], 32'd0);
        push_both(32'h55);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_src();
        repeat (3) tick();

        // Single-register hold, combinational ready, then stall saturation.
        pulse_reset("rst_hold");
        push_both(32'h77);
        out_ready = 1'b0;
        tick();
        repeat (5) tick();
        check_eq("hold_stall", 32'(stall_b), 32'd5);
        check_eq("hold_data", out_data_w[1], 32'h77);
        out_ready = 1'b1;
        #1;
        check_eq("comb_rdy_hi", 32'(in_ready_w[1]), 32'd1);
        out_ready = 1'b0;
        #1;
        check_eq("comb_rdy_lo", 32'(in_ready_w[1]), 32'd0);
        repeat (15) tick();
        check_eq("sat_stall", 32'(stall_b), 32'd15);

        // Randomised traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                vgate[i] = ($urandom_range(0, 3) != 0);
                if (src_wr[i] - src_rd[i] < 4) push_src(i, 32'h0001_0000 | 32'($urandom_range(0, 65535)));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
            flush = 1'b0;
        end

        check_eq("never_55", 32'(seen55), 32'd0);
        check_eq("flop_max_occ", 32'(max_occ_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register that replaces the bare IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers of the five-stage RISC-V core. It carries a payload of any width, normally one of the packed stage structs, under a valid/ready handshake. It adds a synchronous flush for branch and jump squash, an optional 2-entry skid mode that registers backpressure, and a saturating stall counter for performance debug. One instance sits between each pair of adjacent pipeline stages.

## Interface
- WIDTH, 32: payload bits; instances use $bits(<stage struct>).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_BUBBLE, 1: 1 = out_data forced to 0 while out_valid=0.
- CNT_W, 16: stall counter width.
- clk  in  1  rising-edge clock, single domain.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held and incoming entries.
- in_valid  in  1  upstream stage presents in_data.
- in_ready  out  1  buffer accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  head entry.
- occupancy  out  2  entries held: 0..2, or 0..1 when SKID=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State register uses states EMPTY, ONE and FULL. FULL exists only when SKID=1.
- Data registers: main holds the head and drives out_data. skid holds the overflow entry and exists only when SKID=1.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data.
  - ONE: in_fire only -> FULL, skid<=in_data (SKID=1). With SKID=0 this case cannot occur, because in_ready=0.
  - ONE: out_fire only -> EMPTY.
  - FULL: out_fire -> ONE, main<=skid. in_fire cannot occur, because in_ready=0.
- Outputs:
  - out_valid = (state != EMPTY).
  - occupancy = 0, 1 or 2 for EMPTY, ONE or FULL.
- in_ready:
  - SKID=1: in_ready = (state != FULL). It is a pure function of the state register, with no combinational path from out_ready.
  - SKID=0: in_ready = ~out_valid | out_ready.
- Flush:
  - Highest priority. Next state is EMPTY regardless of in_fire or out_fire.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream.
  - in_ready is not masked by flush.
- ZERO_BUBBLE=1: main and skid are cleared to 0 when their entry leaves without replacement and on flush. out_data=0 whenever out_valid=0.
- stall_cnt increments each cycle with out_valid & ~out_ready. It saturates at 2^CNT_W-1 and is not cleared by flush.

## Timing
- Reset (reset_n low, asynchronous): state=EMPTY, main=skid=0, stall_cnt=0. Consequently out_valid=0, occupancy=0, out_data=0, and in_ready=1.
- Latency: an entry accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one entry per cycle sustained while out_ready=1, in both modes.
- SKID=1 backpressure:
  - out_ready dropping with the buffer in ONE lets one more entry be accepted (FULL). in_ready falls the next cycle.
  - Recovery: the first out_fire from FULL raises in_ready at the following edge.
- Simultaneous flush and reset: reset dominates.
- reset_n deassertion is synchronised externally. The first active edge after release behaves as EMPTY.
- Ordering: strict FIFO. The skid entry is never emitted ahead of main.

## Structure
- Shared package pipe_pkg holds:
  - the stage payload structs;
  - typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_buf_state_e;
  - localparams for the default WIDTH and CNT_W.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and a counter reset; output count), is used for stall_cnt.
- The SKID and ZERO_BUBBLE variants are selected with generate blocks inside pipe_stage_buf, not with separate modules.

## Test plan
- Reset mid-stream: buffer FULL with 0xA1, 0xA2; assert reset_n=0 asynchronously between edges -> out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0 immediately.
- Streaming, SKID=1, out_ready=1: inputs 0x1..0x8 back-to-back -> outputs 0x1..0x8 one cycle later, no gaps, in_ready stays 1.
- Backpressure, SKID=1: stream 0x10, 0x11, 0x12 with out_ready=0 from cycle 1 -> occupancy 2, in_ready=0, out_data=0x10, stall_cnt increments each cycle. Release out_ready -> outputs 0x10, 0x11, 0x12 in order.
- Flush with simultaneous input: FULL buffer; flush=1 with in_valid=1, in_data=0x55 -> next cycle EMPTY, out_data=0, and 0x55 is never emitted.
- SKID=0: in_ready tracks out_ready combinationally while ONE. The buffer never reaches occupancy 2. A held entry with out_ready=0 is stable for 5 cycles, and stall_cnt=5.
- Saturation, CNT_W=4: out_ready=0 for 20 cycles with valid data -> stall_cnt holds at 15.
